// File: rtl/cpu_control_pkg.sv
// Shared codes for the multicycle MIPS control unit: FSM states, the opcode and
// function fields it understands, the write-data / write-address select codes,
// and the bundles passed between the decoder and the FSM.
package cpu_control_pkg;

  typedef enum logic [2:0] {
    S_HALTED = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC1  = 3'd2,
    S_EXEC2  = 3'd3,
    S_MULDIV = 3'd4
  } state_t;

  typedef enum logic [5:0] {
    OP_R_TYPE = 6'h00,
    OP_J      = 6'h02,
    OP_JAL    = 6'h03,
    OP_ADDIU  = 6'h09,
    OP_LW     = 6'h23,
    OP_SW     = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FUNC_JR    = 6'h08,
    FUNC_MFHI  = 6'h10,
    FUNC_MFLO  = 6'h12,
    FUNC_MULT  = 6'h18,
    FUNC_MULTU = 6'h19,
    FUNC_DIV   = 6'h1A,
    FUNC_DIVU  = 6'h1B,
    FUNC_ADDU  = 6'h21
  } func_t;

  typedef enum logic [1:0] {
    WD_MEM  = 2'd0,
    WD_ALU  = 2'd1,
    WD_PC8  = 2'd2,
    WD_HILO = 2'd3
  } wd_sel_t;

  typedef enum logic [1:0] {
    A3_RT  = 2'd0,
    A3_RD  = 2'd1,
    A3_R31 = 2'd2
  } a3_sel_t;

  // Instruction class produced by the decoder.
  // uses_imm marks instructions whose EXEC2 operand B is the immediate
  // (ADDIU, SW); LW uses the immediate in EXEC1 and is driven by is_load.
  typedef struct packed {
    logic    is_load;
    logic    is_store;
    logic    is_jump;
    logic    is_muldiv;
    logic    writes_reg;
    logic    uses_imm;
    wd_sel_t wd_sel;
    a3_sel_t a3_sel;
    logic    illegal;
  } instr_class_t;

  // Datapath enables and selects, gathered so they can be squashed as one.
  typedef struct packed {
    logic       pc_wen;
    logic       ir_wen;
    logic       ram_wen;
    logic       ram_rds;
    logic       reg_wen;
    logic       src_b_sel;
    logic       ram_a_sel;
    logic [1:0] reg_wd_sel;
    logic [1:0] reg_a3_sel;
    logic       muldiv_start;
  } ctrl_t;

endpackage

// File: rtl/cpu_control_decode.sv
// Purpose: classify opcode/function into load/store/jump/muldiv/reg-write info.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, output follows the inputs.
// Ports: opcode, funct (instruction fields) -> cls (instr_class_t).
module cpu_control_decode
  import cpu_control_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_LW: begin
        cls.is_load    = 1'b1;
        cls.writes_reg = 1'b1;
        cls.wd_sel     = WD_MEM;
        cls.a3_sel     = A3_RT;
      end
      OP_SW: begin
        cls.is_store = 1'b1;
        cls.uses_imm = 1'b1;
      end
      OP_ADDIU: begin
        cls.writes_reg = 1'b1;
        cls.uses_imm   = 1'b1;
        cls.wd_sel     = WD_ALU;
        cls.a3_sel     = A3_RT;
      end
      OP_J: begin
        cls.is_jump = 1'b1;
      end
      OP_JAL: begin
        cls.is_jump    = 1'b1;
        cls.writes_reg = 1'b1;
        cls.wd_sel     = WD_PC8;
        cls.a3_sel     = A3_R31;
      end
      OP_R_TYPE: begin
        case (funct)
          FUNC_JR:   cls.is_jump = 1'b1;
          FUNC_ADDU: begin
            cls.writes_reg = 1'b1;
            cls.wd_sel     = WD_ALU;
            cls.a3_sel     = A3_RD;
          end
          FUNC_MFHI, FUNC_MFLO: begin
            cls.writes_reg = 1'b1;
            cls.wd_sel     = WD_HILO;
            cls.a3_sel     = A3_RD;
          end
          FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: cls.is_muldiv = 1'b1;
          default: cls.illegal = 1'b1;
        endcase
      end
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Purpose: multicycle MIPS control FSM driving datapath enables and mux selects.
// Latency: 3 cycles per instruction, 3+MULDIV_CYCLES for MULT/DIV, plus stalls.
// Backpressure: waitrequest_i holds the current bus request (FETCH, LW EXEC1, SW EXEC2).
// Ports: clk_i, reset_i (async high); waitrequest_i, opcode_i, function_i,
//   pc_next_zero_i in; state_o, active_o, illegal_o, datapath enables/selects,
//   muldiv_start_o out. All outputs are combinational from state and inputs.
module cpu_control_fsm
  import cpu_control_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int WAIT_TIMEOUT  = 0,
  parameter int HALT_ON_ZERO  = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       waitrequest_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] function_i,
  input  logic       pc_next_zero_i,
  output logic [2:0] state_o,
  output logic       active_o,
  output logic       illegal_o,
  output logic       pc_wen_o,
  output logic       ir_wen_o,
  output logic       ram_wen_o,
  output logic       ram_rds_o,
  output logic       reg_wen_o,
  output logic       src_b_sel_o,
  output logic       ram_a_sel_o,
  output logic [1:0] reg_wd_sel_o,
  output logic [1:0] reg_a3_sel_o,
  output logic       muldiv_start_o
);

  localparam int MDW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [MDW-1:0] MD_LAST = MDW'(MULDIV_CYCLES - 1);
  localparam int WCW = 16;
  // Timeout fires on the WAIT_TIMEOUT-th consecutive stalled cycle.
  localparam logic [WCW-1:0] WAIT_LIMIT = (WAIT_TIMEOUT > 0) ? WCW'(WAIT_TIMEOUT - 1) : '0;

  state_t         state, next_state;
  instr_class_t   cls;
  ctrl_t          ctrl;
  logic           ir_done;
  logic           booted;     // remembers that the post-reset HALTED->FETCH hop happened
  logic           illegal_q;
  logic           set_illegal;
  logic           timeout;
  logic [WCW-1:0] wait_cnt;
  logic [MDW-1:0] md_cnt;

  cpu_control_decode u_decode (
    .opcode (opcode_i),
    .funct  (function_i),
    .cls    (cls)
  );

  assign timeout = (WAIT_TIMEOUT != 0) && waitrequest_i &&
                   (state != S_HALTED) && (wait_cnt >= WAIT_LIMIT);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= S_HALTED;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    ctrl        = '0;
    set_illegal = 1'b0;
    case (state)
      S_HALTED: begin
        if (!booted) next_state = S_FETCH;
      end
      S_FETCH: begin
        ctrl.ram_rds = 1'b1;
        if (!waitrequest_i) next_state = S_EXEC1;
      end
      S_EXEC1: begin
        if (cls.illegal) begin
          set_illegal = 1'b1;
          next_state  = S_HALTED;
        end else begin
          // IR captures the fetched word once; later stall cycles keep it.
          ctrl.ir_wen = !ir_done;
          if (cls.is_load) begin
            ctrl.ram_rds   = 1'b1;
            ctrl.ram_a_sel = 1'b1;
            ctrl.src_b_sel = 1'b1;
            if (!waitrequest_i) next_state = S_EXEC2;
          end else if (cls.is_muldiv) begin
            ctrl.muldiv_start = !ir_done;
            next_state        = S_MULDIV;
          end else begin
            next_state = S_EXEC2;
          end
        end
      end
      S_MULDIV: begin
        if (md_cnt == MD_LAST) next_state = S_EXEC2;
      end
      S_EXEC2: begin
        ctrl.reg_wen    = cls.writes_reg;
        ctrl.reg_wd_sel = cls.wd_sel;
        ctrl.reg_a3_sel = cls.a3_sel;
        ctrl.src_b_sel  = cls.uses_imm;
        if (cls.is_store) begin
          ctrl.ram_wen   = 1'b1;
          ctrl.ram_a_sel = 1'b1;
        end
        if (cls.is_store && waitrequest_i) begin
          next_state = S_EXEC2;
        end else begin
          ctrl.pc_wen = 1'b1;
          if ((HALT_ON_ZERO != 0) && cls.is_jump && pc_next_zero_i) next_state = S_HALTED;
          else next_state = S_FETCH;
        end
      end
      default: next_state = S_HALTED;
    endcase

    if (timeout) begin
      ctrl        = '0;
      set_illegal = 1'b1;
      next_state  = S_HALTED;
    end
    // State is already HALTED under reset; this also covers the edge itself.
    if (reset_i) ctrl = '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      booted    <= 1'b0;
      ir_done   <= 1'b0;
      illegal_q <= 1'b0;
      wait_cnt  <= '0;
      md_cnt    <= '0;
    end else begin
      booted  <= 1'b1;
      ir_done <= (state == S_EXEC1) && (next_state == S_EXEC1);
      if (set_illegal) illegal_q <= 1'b1;
      if (!waitrequest_i) wait_cnt <= '0;
      else if (wait_cnt != {WCW{1'b1}}) wait_cnt <= wait_cnt + 1'b1;
      if ((state == S_MULDIV) && (next_state == S_MULDIV)) md_cnt <= md_cnt + 1'b1;
      else md_cnt <= '0;
    end
  end

  assign state_o        = state;
  assign active_o       = (state != S_HALTED);
  assign illegal_o      = illegal_q;
  assign pc_wen_o       = ctrl.pc_wen;
  assign ir_wen_o       = ctrl.ir_wen;
  assign ram_wen_o      = ctrl.ram_wen;
  assign ram_rds_o      = ctrl.ram_rds;
  assign reg_wen_o      = ctrl.reg_wen;
  assign src_b_sel_o    = ctrl.src_b_sel;
  assign ram_a_sel_o    = ctrl.ram_a_sel;
  assign reg_wd_sel_o   = ctrl.reg_wd_sel;
  assign reg_a3_sel_o   = ctrl.reg_a3_sel;
  assign muldiv_start_o = ctrl.muldiv_start;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: instruction-level timeline model expands each
// instruction into expected per-cycle outputs, then replays the inputs and
// compares the DUT every cycle; literal tallies pin the key latencies.
module tb_cpu_control_fsm;
  import cpu_control_pkg::*;

  localparam int MDC = 4;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       waitrequest_i = 1'b0;
  logic [5:0] opcode_i = 6'h0;
  logic [5:0] function_i = 6'h0;
  logic       pc_next_zero_i = 1'b0;
  logic [2:0] state_o;
  logic       active_o, illegal_o, pc_wen_o, ir_wen_o, ram_wen_o, ram_rds_o;
  logic       reg_wen_o, src_b_sel_o, ram_a_sel_o, muldiv_start_o;
  logic [1:0] reg_wd_sel_o, reg_a3_sel_o;

  cpu_control_fsm #(.MULDIV_CYCLES(MDC), .WAIT_TIMEOUT(0), .HALT_ON_ZERO(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .waitrequest_i(waitrequest_i),
    .opcode_i(opcode_i), .function_i(function_i), .pc_next_zero_i(pc_next_zero_i),
    .state_o(state_o), .active_o(active_o), .illegal_o(illegal_o),
    .pc_wen_o(pc_wen_o), .ir_wen_o(ir_wen_o), .ram_wen_o(ram_wen_o), .ram_rds_o(ram_rds_o),
    .reg_wen_o(reg_wen_o), .src_b_sel_o(src_b_sel_o), .ram_a_sel_o(ram_a_sel_o),
    .reg_wd_sel_o(reg_wd_sel_o), .reg_a3_sel_o(reg_a3_sel_o), .muldiv_start_o(muldiv_start_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0] st;
    logic act, ill, pcw, irw, ramw, rds, regw, srcb, rama;
    logic [1:0] wd, a3;
    logic mds;
  } obs_t;

  typedef struct packed {
    logic wr;
    logic [5:0] op, fn;
    logic pcz;
    obs_t e;
  } rec_t;

  rec_t q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0;
  int   t_rds, t_irw, t_mds, t_pcw, t_ramw, t_first_e2, t_idx;
  logic ill_m = 1'b0;

  function automatic obs_t base(state_t s);
    obs_t r;
    r = '0;
    r.st  = s;
    r.act = (s != S_HALTED);
    r.ill = ill_m;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.st = state_o; r.act = active_o; r.ill = illegal_o; r.pcw = pc_wen_o;
    r.irw = ir_wen_o; r.ramw = ram_wen_o; r.rds = ram_rds_o; r.regw = reg_wen_o;
    r.srcb = src_b_sel_o; r.rama = ram_a_sel_o; r.wd = reg_wd_sel_o;
    r.a3 = reg_a3_sel_o; r.mds = muldiv_start_o;
    return r;
  endfunction

  task automatic push(input logic wr, input logic [5:0] op, input logic [5:0] fn,
                      input logic pcz, input obs_t e);
    rec_t r;
    r.wr = wr; r.op = op; r.fn = fn; r.pcz = pcz; r.e = e;
    q.push_back(r);
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic chk_obs(input string nm, input obs_t want);
    obs_t got;
    got = sample();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %b want %b", nm, got, want);
    end
  endtask

  // Expand one instruction into its cycle-by-cycle expectation.
  // f_st: stalled FETCH cycles; e1_wr: waitrequest cycles in EXEC1 (only LW stalls);
  // e2_st: waitrequest cycles in EXEC2 (only SW stalls).
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int f_st,
                       input int e1_wr, input int e2_st, input logic pcz);
    bit rt, lw, sw, addiu, jj, jal, jr, addu, mf, md, legal;
    int n;
    obs_t e;
    rt = (op == 6'h00); lw = (op == 6'h23); sw = (op == 6'h2B); addiu = (op == 6'h09);
    jj = (op == 6'h02); jal = (op == 6'h03);
    jr = rt && (fn == 6'h08); addu = rt && (fn == 6'h21);
    mf = rt && (fn == 6'h10 || fn == 6'h12);
    md = rt && (fn >= 6'h18 && fn <= 6'h1B);
    legal = lw | sw | addiu | jj | jal | jr | addu | mf | md;
    for (int i = 0; i <= f_st; i++) begin
      e = base(S_FETCH); e.rds = 1'b1;
      push(i < f_st, op, fn, 1'b0, e);
    end
    if (!legal) begin
      push(1'b0, op, fn, 1'b0, base(S_EXEC1));
      ill_m = 1'b1;
      return;
    end
    if (lw) begin
      for (int i = 0; i <= e1_wr; i++) begin
        e = base(S_EXEC1); e.irw = (i == 0); e.rds = 1'b1; e.rama = 1'b1; e.srcb = 1'b1;
        push(i < e1_wr, op, fn, 1'b0, e);
      end
    end else begin
      e = base(S_EXEC1); e.irw = 1'b1; e.mds = md;
      push(e1_wr != 0, op, fn, 1'b0, e);
    end
    if (md) for (int i = 0; i < MDC; i++) push(1'b0, op, fn, 1'b0, base(S_MULDIV));
    n = sw ? e2_st + 1 : 1;
    for (int i = 0; i < n; i++) begin
      e = base(S_EXEC2);
      e.pcw = (i == n - 1);
      if (sw)    begin e.ramw = 1'b1; e.rama = 1'b1; e.srcb = 1'b1; end
      if (lw)    begin e.regw = 1'b1; e.wd = 2'd0; e.a3 = 2'd0; end
      if (addiu) begin e.regw = 1'b1; e.srcb = 1'b1; e.wd = 2'd1; e.a3 = 2'd0; end
      if (addu)  begin e.regw = 1'b1; e.wd = 2'd1; e.a3 = 2'd1; end
      if (mf)    begin e.regw = 1'b1; e.wd = 2'd3; e.a3 = 2'd1; end
      if (jal)   begin e.regw = 1'b1; e.wd = 2'd2; e.a3 = 2'd2; end
      push(sw && (i < e2_st), op, fn, pcz, e);
    end
  endtask

  task automatic halted(input int n, input logic wr);
    for (int i = 0; i < n; i++) push(wr, 6'h00, 6'h00, 1'b0, base(S_HALTED));
  endtask

  // Replay queued cycles: drive after the rising edge, compare at the falling edge.
  task automatic run();
    obs_t got;
    t_rds = 0; t_irw = 0; t_mds = 0; t_pcw = 0; t_ramw = 0; t_first_e2 = -1; t_idx = 0;
    while (q.size() > 0) begin
      rec_t r;
      r = q.pop_front();
      @(posedge clk_i); #1;
      waitrequest_i = r.wr; opcode_i = r.op; function_i = r.fn; pc_next_zero_i = r.pcz;
      @(negedge clk_i);
      got = sample();
      n_cmp++;
      if (got !== r.e) begin
        n_bad++;
        $display("FAIL cyc%0d st/act/ill/pcw/irw/ramw/rds/regw/srcb/rama/wd/a3/mds got %b want %b",
                 cyc, got, r.e);
      end
      t_rds += int'(got.rds); t_irw += int'(got.irw); t_mds += int'(got.mds);
      t_pcw += int'(got.pcw); t_ramw += int'(got.ramw);
      if (t_first_e2 < 0 && got.st == S_EXEC2) t_first_e2 = t_idx;
      t_idx++; cyc++;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk_i); #1;
    reset_i = 1'b1; waitrequest_i = 1'b0; opcode_i = 6'h0; function_i = 6'h0; pc_next_zero_i = 1'b0;
    ill_m = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      chk_obs("rst_hold", base(S_HALTED));
    end
    @(posedge clk_i); #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk_obs("rst_release", base(S_HALTED));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);

    instr(6'h09, 6'h00, 0, 0, 0, 1'b0); run();            // ADDIU
    chk("addiu_first_exec2", t_first_e2, 2);
    chk("addiu_pc_wen", t_pcw, 1);

    instr(6'h23, 6'h00, 0, 4, 0, 1'b0); run();            // LW, 4 stalls in EXEC1
    chk("lw_ir_wen", t_irw, 1);
    chk("lw_ram_rds", t_rds, 6);
    chk("lw_first_exec2", t_first_e2, 6);

    instr(6'h2B, 6'h00, 0, 0, 2, 1'b0); run();            // SW, 2 stalls in EXEC2
    chk("sw_ram_wen", t_ramw, 3);
    chk("sw_pc_wen", t_pcw, 1);

    instr(6'h00, 6'h21, 2, 0, 0, 1'b0); run();            // ADDU, 2 fetch stalls
    chk("addu_first_exec2", t_first_e2, 4);

    instr(6'h00, 6'h1B, 0, 0, 0, 1'b0); run();            // DIVU
    chk("divu_start_pulses", t_mds, 1);
    chk("divu_first_exec2", t_first_e2, 6);

    instr(6'h00, 6'h12, 0, 0, 0, 1'b0);                   // MFLO
    instr(6'h03, 6'h00, 0, 0, 0, 1'b0);                   // JAL, non-zero target
    instr(6'h02, 6'h00, 0, 0, 0, 1'b0);                   // J, non-zero target
    instr(6'h09, 6'h00, 0, 1, 0, 1'b0);                   // ADDIU, waitrequest in EXEC1 ignored
    instr(6'h00, 6'h08, 0, 0, 0, 1'b1);                   // JR to zero -> halt
    halted(3, 1'b0);
    halted(1, 1'b1);
    run();
    chk("halt_active", int'(active_o), 0);

    do_reset(1);
    instr(6'h3F, 6'h00, 0, 0, 0, 1'b0);                   // undefined opcode
    halted(2, 1'b0);
    run();
    chk("ill_opcode_flag", int'(illegal_o), 1);

    do_reset(1);
    instr(6'h00, 6'h2A, 0, 0, 0, 1'b0);                   // undefined function
    halted(1, 1'b0);
    run();

    do_reset(1);
    for (int i = 0; i < 2; i++) begin
      obs_t e;
      e = base(S_FETCH); e.rds = 1'b1;
      push(1'b1, 6'h23, 6'h00, 1'b0, e);
    end
    run();
    #2 reset_i = 1'b1;                                    // mid-stall, between edges
    #1;
    chk("async_rst_rds", int'(ram_rds_o), 0);
    chk("async_rst_state", int'(state_o), int'(S_HALTED));
    @(posedge clk_i); #1 reset_i = 1'b0; waitrequest_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
